decode_stage_hz: RTL and testbench

DECODE_STAGE_HZ -- requirements
Module: decode_stage_hz

---
 rtl/decode_stage_hz.sv | 272 +++++++++++++++++++++++++++
 tb/tb_decode_stage_hz.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_hz.sv
// Decode stage with internal register file, WB bypass, load-use hazard
// detection and a DE/EX pipeline register with saturating performance counters.

module control_unit #(
    parameter int ALU_OP_W = 3
) (
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    output logic                has_imm,
    output logic                alu_alt,
    output logic                rf_we,
    output logic                mem_we,
    output logic                mem2rf,
    output logic                branch,
    output logic                check_eq,
    output logic [ALU_OP_W-1:0] alu_op
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        has_imm  = 1'b0;
        alu_alt  = 1'b0;
        rf_we    = 1'b0;
        mem_we   = 1'b0;
        mem2rf   = 1'b0;
        branch   = 1'b0;
        check_eq = 1'b0;
        alu_op   = '0;
        case (opcode)
            OPC_OP: begin
                rf_we   = 1'b1;
                alu_op  = ALU_OP_W'(funct3);
                alu_alt = (funct7 == 7'b0100000);
            end
            OPC_OP_IMM: begin
                rf_we   = 1'b1;
                has_imm = 1'b1;
                alu_op  = ALU_OP_W'(funct3);
                // Only the shift-right immediate form uses funct7 to pick arithmetic.
                alu_alt = (funct3 == 3'b101) && (funct7 == 7'b0100000);
            end
            OPC_LOAD: begin
                rf_we   = 1'b1;
                has_imm = 1'b1;
                mem2rf  = 1'b1;
            end
            OPC_STORE: begin
                has_imm = 1'b1;
                mem_we  = 1'b1;
            end
            OPC_BRANCH: begin
                branch   = 1'b1;
                alu_alt  = 1'b1;
                check_eq = (funct3 == 3'b000);
            end
            default: ;
        endcase
    end

endmodule

module decode_stage_hz #(
    parameter int PC_W     = 32,
    parameter int INSTR_W  = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int ALU_OP_W = 3,
    parameter int IMM_W    = 32,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fe_valid_i,
    input  logic [INSTR_W-1:0]  instr_i,
    input  logic [PC_W-1:0]     pc_plus1_i,
    output logic                fe_ready_o,
    input  logic                ex_ready_i,
    input  logic                flush_i,
    input  logic [ADDR_W-1:0]   rf_waddr_i,
    input  logic [DATA_W-1:0]   rf_wdata_i,
    input  logic                rf_we_i,
    output logic                ex_valid_o,
    output logic                has_imm_o,
    output logic                alu_alt_o,
    output logic                rf_we_o,
    output logic                mem_we_o,
    output logic                mem2rf_o,
    output logic                branch_o,
    output logic                check_eq_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [IMM_W-1:0]    imm32_o,
    output logic [DATA_W-1:0]   rf_data0_o,
    output logic [DATA_W-1:0]   rf_data1_o,
    output logic [ADDR_W-1:0]   rs0_o,
    output logic [ADDR_W-1:0]   rs1_o,
    output logic [ADDR_W-1:0]   rf_waddr_o,
    output logic [PC_W-1:0]     pc_plus1_o,
    output logic [CNT_W-1:0]    stall_cnt_o,
    output logic [CNT_W-1:0]    flush_cnt_o
);

    typedef enum logic [1:0] {
        ACT_FLUSH,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_LOAD
    } act_e;

    logic                dec_has_imm;
    logic                dec_alu_alt;
    logic                dec_rf_we;
    logic                dec_mem_we;
    logic                dec_mem2rf;
    logic                dec_branch;
    logic                dec_check_eq;
    logic [ALU_OP_W-1:0] dec_alu_op;
    logic [11:0]         imm12;
    logic [IMM_W-1:0]    dec_imm;
    logic [ADDR_W-1:0]   rs0_dec;
    logic [ADDR_W-1:0]   rs1_dec;
    logic [ADDR_W-1:0]   rd_dec;
    logic [DATA_W-1:0]   rd0_val;
    logic [DATA_W-1:0]   rd1_val;
    logic                wb_en;
    logic                advance;
    logic                hazard;
    act_e                act;

    logic [DATA_W-1:0]   regs [2**ADDR_W];

    control_unit #(
        .ALU_OP_W (ALU_OP_W)
    ) u_ctrl (
        .opcode   (instr_i[6:0]),
        .funct3   (instr_i[14:12]),
        .funct7   (instr_i[31:25]),
        .has_imm  (dec_has_imm),
        .alu_alt  (dec_alu_alt),
        .rf_we    (dec_rf_we),
        .mem_we   (dec_mem_we),
        .mem2rf   (dec_mem2rf),
        .branch   (dec_branch),
        .check_eq (dec_check_eq),
        .alu_op   (dec_alu_op)
    );

    assign rs0_dec = instr_i[15 +: ADDR_W];
    assign rs1_dec = instr_i[20 +: ADDR_W];
    assign rd_dec  = instr_i[7 +: ADDR_W];

    always_comb begin
        if (dec_mem_we) begin
            imm12 = {instr_i[31:25], instr_i[11:7]};
        end else if (dec_branch) begin
            imm12 = {instr_i[31], instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:9]};
        end else begin
            imm12 = instr_i[31:20];
        end
    end

    assign dec_imm = {{(IMM_W-12){imm12[11]}}, imm12};

    // Register file; x0 is never written and always reads as zero.
    assign wb_en = rf_we_i && (rf_waddr_i != '0);

    // NOTE: the array has no reset branch; its contents survive reset, and
    // keeping it reset-free lets it map onto plain storage.
    always_ff @(posedge clk) begin
        if (wb_en) begin
            regs[rf_waddr_i] <= rf_wdata_i;
        end
    end

    assign rd0_val = (rs0_dec == '0)                  ? '0         :
                     (wb_en && rf_waddr_i == rs0_dec) ? rf_wdata_i : regs[rs0_dec];
    assign rd1_val = (rs1_dec == '0)                  ? '0         :
                     (wb_en && rf_waddr_i == rs1_dec) ? rf_wdata_i : regs[rs1_dec];

    // A load in DE/EX whose result is needed by the fetch instruction cannot
    // be forwarded in time, so the consumer waits one cycle behind a bubble.
    assign advance = ex_ready_i || !ex_valid_o;
    assign hazard  = fe_valid_i && ex_valid_o && mem2rf_o && (rf_waddr_o != '0) &&
                     ((rf_waddr_o == rs0_dec) ||
                      ((rf_waddr_o == rs1_dec) && (!dec_has_imm || dec_mem_we || dec_branch)));

    assign fe_ready_o = flush_i || (advance && !hazard);

    always_comb begin
        act = ACT_LOAD;
        if (flush_i) begin
            act = ACT_FLUSH;
        end else if (!advance) begin
            act = ACT_HOLD;
        end else if (hazard) begin
            act = ACT_BUBBLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_o <= 1'b0;
            has_imm_o  <= 1'b0;
            alu_alt_o  <= 1'b0;
            rf_we_o    <= 1'b0;
            mem_we_o   <= 1'b0;
            mem2rf_o   <= 1'b0;
            branch_o   <= 1'b0;
            check_eq_o <= 1'b0;
            alu_op_o   <= '0;
            imm32_o    <= '0;
            rf_data0_o <= '0;
            rf_data1_o <= '0;
            rs0_o      <= '0;
            rs1_o      <= '0;
            rf_waddr_o <= '0;
            pc_plus1_o <= '0;
        end else begin
            case (act)
                ACT_FLUSH, ACT_BUBBLE: begin
                    ex_valid_o <= 1'b0;
                end
                ACT_HOLD: begin
                    // Operands of a stalled instruction keep tracking WB writes.
                    if (wb_en && rf_waddr_i == rs0_o) rf_data0_o <= rf_wdata_i;
                    if (wb_en && rf_waddr_i == rs1_o) rf_data1_o <= rf_wdata_i;
                end
                default: begin
                    ex_valid_o <= fe_valid_i;
                    has_imm_o  <= dec_has_imm;
                    alu_alt_o  <= dec_alu_alt;
                    rf_we_o    <= dec_rf_we;
                    mem_we_o   <= dec_mem_we;
                    mem2rf_o   <= dec_mem2rf;
                    branch_o   <= dec_branch;
                    check_eq_o <= dec_check_eq;
                    alu_op_o   <= dec_alu_op;
                    imm32_o    <= dec_imm;
                    rf_data0_o <= rd0_val;
                    rf_data1_o <= rd1_val;
                    rs0_o      <= rs0_dec;
                    rs1_o      <= rs1_dec;
                    rf_waddr_o <= rd_dec;
                    pc_plus1_o <= pc_plus1_i;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (act == ACT_BUBBLE && stall_cnt_o != '1) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (flush_i && (fe_valid_i || ex_valid_o) && flush_cnt_o != '1) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_hz.sv
// Self-checking bench for decode_stage_hz: directed scenarios followed by
// randomized traffic compared against a transaction-level reference model.

module tb_decode_stage_hz;

    typedef struct packed {
        logic        has_imm;
        logic        alu_alt;
        logic        rf_we;
        logic        mem_we;
        logic        mem2rf;
        logic        branch;
        logic        check_eq;
        logic [2:0]  alu_op;
        logic [31:0] imm;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic [31:0] pc;
    } pay_t;

    localparam logic [31:0] ADDI_X1 = 32'h00500093;
    localparam logic [31:0] ADD_X4  = 32'h00018233;
    localparam logic [31:0] LW_X5   = 32'h00002283;
    localparam logic [31:0] ADD_X6  = 32'h00528333;

    logic        clk = 1'b0;
    logic        reset;
    logic        fe_valid_i;
    logic [31:0] instr_i;
    logic [31:0] pc_plus1_i;
    logic        ex_ready_i;
    logic        flush_i;
    logic [4:0]  rf_waddr_i;
    logic [31:0] rf_wdata_i;
    logic        rf_we_i;

    logic        fe_ready_o, ex_valid_o;
    logic        has_imm_o, alu_alt_o, rf_we_o, mem_we_o, mem2rf_o, branch_o, check_eq_o;
    logic [2:0]  alu_op_o;
    logic [31:0] imm32_o, rf_data0_o, rf_data1_o, pc_plus1_o;
    logic [4:0]  rs0_o, rs1_o, rf_waddr_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    logic        s_fe_ready, s_ex_valid;
    logic        s_has_imm, s_alu_alt, s_rf_we, s_mem_we, s_mem2rf, s_branch, s_check_eq;
    logic [2:0]  s_alu_op;
    logic [31:0] s_imm32, s_rf_data0, s_rf_data1, s_pc_plus1;
    logic [4:0]  s_rs0, s_rs1, s_rf_waddr;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic        m_valid;
    pay_t        m_pay;
    int          m_stall;
    int          m_flush;
    logic [31:0] m_rf [32];

    always #5 clk = ~clk;

    decode_stage_hz dut (
        .clk(clk), .reset(reset), .fe_valid_i(fe_valid_i), .instr_i(instr_i),
        .pc_plus1_i(pc_plus1_i), .fe_ready_o(fe_ready_o), .ex_ready_i(ex_ready_i),
        .flush_i(flush_i), .rf_waddr_i(rf_waddr_i), .rf_wdata_i(rf_wdata_i),
        .rf_we_i(rf_we_i), .ex_valid_o(ex_valid_o), .has_imm_o(has_imm_o),
        .alu_alt_o(alu_alt_o), .rf_we_o(rf_we_o), .mem_we_o(mem_we_o),
        .mem2rf_o(mem2rf_o), .branch_o(branch_o), .check_eq_o(check_eq_o),
        .alu_op_o(alu_op_o), .imm32_o(imm32_o), .rf_data0_o(rf_data0_o),
        .rf_data1_o(rf_data1_o), .rs0_o(rs0_o), .rs1_o(rs1_o),
        .rf_waddr_o(rf_waddr_o), .pc_plus1_o(pc_plus1_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    decode_stage_hz #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .fe_valid_i(fe_valid_i), .instr_i(instr_i),
        .pc_plus1_i(pc_plus1_i), .fe_ready_o(s_fe_ready), .ex_ready_i(ex_ready_i),
        .flush_i(flush_i), .rf_waddr_i(rf_waddr_i), .rf_wdata_i(rf_wdata_i),
        .rf_we_i(rf_we_i), .ex_valid_o(s_ex_valid), .has_imm_o(s_has_imm),
        .alu_alt_o(s_alu_alt), .rf_we_o(s_rf_we), .mem_we_o(s_mem_we),
        .mem2rf_o(s_mem2rf), .branch_o(s_branch), .check_eq_o(s_check_eq),
        .alu_op_o(s_alu_op), .imm32_o(s_imm32), .rf_data0_o(s_rf_data0),
        .rf_data1_o(s_rf_data1), .rs0_o(s_rs0), .rs1_o(s_rs1),
        .rf_waddr_o(s_rf_waddr), .pc_plus1_o(s_pc_plus1),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    wire [185:0] all_regs = {ex_valid_o, has_imm_o, alu_alt_o, rf_we_o, mem_we_o, mem2rf_o,
                             branch_o, check_eq_o, alu_op_o, imm32_o, rf_data0_o, rf_data1_o,
                             rs0_o, rs1_o, rf_waddr_o, pc_plus1_o, stall_cnt_o, flush_cnt_o};
    wire pay_t   act_pay  = {has_imm_o, alu_alt_o, rf_we_o, mem_we_o, mem2rf_o, branch_o,
                             check_eq_o, alu_op_o, imm32_o, rf_data0_o, rf_data1_o,
                             rs0_o, rs1_o, rf_waddr_o, pc_plus1_o};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decoding rules expressed as an opcode table plus the immediate selection order.
    function automatic pay_t decode_ref(input logic [31:0] ins);
        pay_t        p;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] i12;
        p  = '0;
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (ins[6:0])
            7'h33: begin p.rf_we = 1'b1; p.alu_op = f3; p.alu_alt = (f7 == 7'h20); end
            7'h13: begin
                p.rf_we = 1'b1; p.has_imm = 1'b1; p.alu_op = f3;
                p.alu_alt = (f3 == 3'd5) && (f7 == 7'h20);
            end
            7'h03: begin p.rf_we = 1'b1; p.has_imm = 1'b1; p.mem2rf = 1'b1; end
            7'h23: begin p.mem_we = 1'b1; p.has_imm = 1'b1; end
            7'h63: begin p.branch = 1'b1; p.alu_alt = 1'b1; p.check_eq = (f3 == 3'd0); end
            default: ;
        endcase
        if (p.mem_we)      i12 = {ins[31:25], ins[11:7]};
        else if (p.branch) i12 = {ins[31], ins[31], ins[7], ins[30:25], ins[11:9]};
        else               i12 = ins[31:20];
        p.imm = 32'($signed(i12));
        p.rs0 = ins[19:15];
        p.rs1 = ins[24:20];
        p.rd  = ins[11:7];
        return p;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (rf_we_i && rf_waddr_i == a) return rf_wdata_i;
        return m_rf[a];
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [4:0]  rd, a, b;
        logic [11:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        rd  = 5'($urandom_range(0, 7));
        a   = 5'($urandom_range(0, 7));
        b   = 5'($urandom_range(0, 7));
        imm = 12'($urandom);
        f3  = 3'($urandom);
        f7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        case ($urandom_range(0, 6))
            0:       return {(f3 == 3'd5) ? f7 : imm[11:5], imm[4:0], a, f3, rd, 7'h13};
            1:       return {f7, b, a, f3, rd, 7'h33};
            2, 3:    return {imm, a, 3'b010, rd, 7'h03};
            4:       return {imm[11:5], b, a, 3'b010, imm[4:0], 7'h23};
            5:       return {imm[11:5], b, a, {2'b00, f3[0]}, imm[4:0], 7'h63};
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        fe_valid_i = 1'b0; instr_i = ADDI_X1; pc_plus1_i = 32'h40;
        ex_ready_i = 1'b1; flush_i = 1'b0; rf_we_i = 1'b0; rf_waddr_i = 5'd0; rf_wdata_i = 32'd0;
        tick();
        tick();
        checks++;
        if (all_regs !== '0) begin
            errors++; $display("FAIL reset_state: got %h want 0", all_regs);
        end
        checks++;
        if (fe_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_fe_ready: got %b want 1", fe_ready_o);
        end
        reset = 1'b0;
        fe_valid_i = 1'b1;
        tick();
        checks++;
        if ({ex_valid_o, pc_plus1_o} !== {1'b1, 32'h40}) begin
            errors++; $display("FAIL first_load: got %b/%h want 1/40", ex_valid_o, pc_plus1_o);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (all_regs !== '0) begin
            errors++; $display("FAIL mid_reset_clear: got %h want 0", all_regs);
        end
        checks++;
        if (fe_ready_o !== 1'b1) begin
            errors++; $display("FAIL mid_reset_fe_ready: got %b want 1", fe_ready_o);
        end
        #1 reset = 1'b0;
        fe_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_decode();
        fe_valid_i = 1'b1; instr_i = ADDI_X1; pc_plus1_i = 32'h100; ex_ready_i = 1'b1;
        #1;
        checks++;
        if (fe_ready_o !== 1'b1) begin
            errors++; $display("FAIL decode_fe_ready: got %b want 1", fe_ready_o);
        end
        tick();
        checks++;
        if ({ex_valid_o, has_imm_o, imm32_o, rf_waddr_o, rf_we_o, mem2rf_o, mem_we_o, branch_o,
             rs0_o, rf_data0_o, pc_plus1_o} !==
            {1'b1, 1'b1, 32'd5, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h100}) begin
            errors++;
            $display("FAIL decode_addi: got v=%b imm=%b/%h rd=%0d we=%b rs0=%0d d0=%h pc=%h want 1 1/5 1 1 0 0 100",
                     ex_valid_o, has_imm_o, imm32_o, rf_waddr_o, rf_we_o, rs0_o, rf_data0_o, pc_plus1_o);
        end
    endtask

    task automatic test_bypass();
        instr_i = ADD_X4; pc_plus1_i = 32'h200;
        rf_we_i = 1'b1; rf_waddr_i = 5'd3; rf_wdata_i = 32'hDEADBEEF;
        tick();
        rf_we_i = 1'b0;
        checks++;
        if ({ex_valid_o, rf_data0_o, rf_data1_o, rs0_o, rs1_o, rf_waddr_o, has_imm_o} !==
            {1'b1, 32'hDEADBEEF, 32'd0, 5'd3, 5'd0, 5'd4, 1'b0}) begin
            errors++;
            $display("FAIL bypass: got v=%b d0=%h d1=%h rs0=%0d rs1=%0d rd=%0d want 1 deadbeef 0 3 0 4",
                     ex_valid_o, rf_data0_o, rf_data1_o, rs0_o, rs1_o, rf_waddr_o);
        end
    endtask

    task automatic test_load_use();
        instr_i = LW_X5; pc_plus1_i = 32'h300;
        tick();
        checks++;
        if ({ex_valid_o, mem2rf_o, rf_waddr_o} !== {1'b1, 1'b1, 5'd5}) begin
            errors++; $display("FAIL load_issue: got %b %b %0d want 1 1 5", ex_valid_o, mem2rf_o, rf_waddr_o);
        end
        instr_i = ADD_X6; pc_plus1_i = 32'h304;
        #1;
        checks++;
        if (fe_ready_o !== 1'b0) begin
            errors++; $display("FAIL load_use_stall: fe_ready got %b want 0", fe_ready_o);
        end
        tick();
        checks++;
        if ({ex_valid_o, stall_cnt_o} !== {1'b0, 16'd1}) begin
            errors++; $display("FAIL load_use_bubble: got v=%b stall=%0d want 0 1", ex_valid_o, stall_cnt_o);
        end
        checks++;
        if (fe_ready_o !== 1'b1) begin
            errors++; $display("FAIL load_use_release: fe_ready got %b want 1", fe_ready_o);
        end
        tick();
        checks++;
        if ({ex_valid_o, rf_waddr_o, rs0_o, rs1_o, mem2rf_o, pc_plus1_o, stall_cnt_o} !==
            {1'b1, 5'd6, 5'd5, 5'd5, 1'b0, 32'h304, 16'd1}) begin
            errors++;
            $display("FAIL load_use_issue: got v=%b rd=%0d rs=%0d/%0d pc=%h stall=%0d want 1 6 5/5 304 1",
                     ex_valid_o, rf_waddr_o, rs0_o, rs1_o, pc_plus1_o, stall_cnt_o);
        end
    endtask

    task automatic test_hold_flush();
        pay_t exp;
        instr_i = ADD_X4; pc_plus1_i = 32'h400; fe_valid_i = 1'b1; ex_ready_i = 1'b1;
        tick();
        exp = '0;
        exp.rf_we = 1'b1; exp.d0 = 32'hDEADBEEF; exp.rs0 = 5'd3; exp.rd = 5'd4; exp.pc = 32'h400;
        ex_ready_i = 1'b0; instr_i = ADDI_X1; pc_plus1_i = 32'h999;
        for (int i = 0; i < 3; i++) begin
            rf_we_i    = (i != 2);
            rf_waddr_i = (i == 0) ? 5'd7 : 5'd3;
            rf_wdata_i = (i == 0) ? 32'hAAAA5555 : 32'h12345678;
            #1;
            checks++;
            if (fe_ready_o !== 1'b0) begin
                errors++; $display("FAIL hold_fe_ready[%0d]: got %b want 0", i, fe_ready_o);
            end
            tick();
            if (i == 1) exp.d0 = 32'h12345678;
            checks++;
            if ({ex_valid_o, act_pay} !== {1'b1, exp}) begin
                errors++; $display("FAIL hold_frozen[%0d]: got %b/%h want 1/%h", i, ex_valid_o, act_pay, exp);
            end
        end
        rf_we_i = 1'b0;
        flush_i = 1'b1;
        #1;
        checks++;
        if (fe_ready_o !== 1'b1) begin
            errors++; $display("FAIL flush_fe_ready: got %b want 1", fe_ready_o);
        end
        tick();
        checks++;
        if ({ex_valid_o, flush_cnt_o, stall_cnt_o} !== {1'b0, 16'd1, 16'd1}) begin
            errors++; $display("FAIL flush: got v=%b flush=%0d stall=%0d want 0 1 1", ex_valid_o, flush_cnt_o, stall_cnt_o);
        end
        flush_i = 1'b0; ex_ready_i = 1'b1; fe_valid_i = 1'b0;
    endtask

    task automatic test_saturation();
        fe_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            instr_i = LW_X5;
            tick();
            instr_i = ADD_X6;
            tick();
            tick();
            if (i == 1) begin
                checks++;
                if ({stall_cnt_o, s_stall_cnt} !== {16'd3, 2'd3}) begin
                    errors++; $display("FAIL sat_reach: got %0d/%0d want 3/3", stall_cnt_o, s_stall_cnt);
                end
            end
        end
        checks++;
        if ({stall_cnt_o, s_stall_cnt, s_flush_cnt} !== {16'd6, 2'd3, 2'd1}) begin
            errors++;
            $display("FAIL sat_hold: got stall=%0d sat_stall=%0d sat_flush=%0d want 6 3 1",
                     stall_cnt_o, s_stall_cnt, s_flush_cnt);
        end
        fe_valid_i = 1'b0;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_pay   = '0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic rand_cycle(input bit init_mode, input int idx);
        pay_t        dec, n_pay;
        logic        n_valid, adv, haz, exp_ready;
        logic [31:0] r0, r1;
        int          n_stall, n_flush;
        if (init_mode) begin
            fe_valid_i = 1'b0; flush_i = 1'b0; rf_we_i = 1'b1; rf_waddr_i = 5'(idx);
        end else begin
            fe_valid_i = ($urandom_range(0, 3) != 0);
            flush_i    = ($urandom_range(0, 15) == 0);
            rf_we_i    = ($urandom_range(0, 1) == 1);
            rf_waddr_i = 5'($urandom_range(0, 7));
        end
        instr_i    = gen_instr();
        pc_plus1_i = $urandom;
        ex_ready_i = ($urandom_range(0, 2) != 0);
        rf_wdata_i = $urandom;
        #2;
        dec = decode_ref(instr_i);
        r0  = ref_read(dec.rs0);
        r1  = ref_read(dec.rs1);
        adv = ex_ready_i || !m_valid;
        haz = fe_valid_i && m_valid && m_pay.mem2rf && (m_pay.rd != 5'd0) &&
              ((m_pay.rd == dec.rs0) || ((m_pay.rd == dec.rs1) && (!dec.has_imm || dec.mem_we || dec.branch)));
        exp_ready = flush_i || (adv && !haz);
        checks++;
        if (fe_ready_o !== exp_ready) begin
            errors++; $display("FAIL rand_fe_ready: got %b want %b instr=%h", fe_ready_o, exp_ready, instr_i);
        end
        n_valid = m_valid; n_pay = m_pay; n_stall = m_stall; n_flush = m_flush;
        if (flush_i) begin
            n_valid = 1'b0;
            if (fe_valid_i || m_valid) n_flush++;
        end else if (!adv) begin
            if (rf_we_i && rf_waddr_i != 5'd0 && rf_waddr_i == m_pay.rs0) n_pay.d0 = rf_wdata_i;
            if (rf_we_i && rf_waddr_i != 5'd0 && rf_waddr_i == m_pay.rs1) n_pay.d1 = rf_wdata_i;
        end else if (haz) begin
            n_valid = 1'b0;
            n_stall++;
        end else begin
            n_valid  = fe_valid_i;
            n_pay    = dec;
            n_pay.d0 = r0;
            n_pay.d1 = r1;
            n_pay.pc = pc_plus1_i;
        end
        tick();
        if (rf_we_i && rf_waddr_i != 5'd0) m_rf[rf_waddr_i] = rf_wdata_i;
        m_valid = n_valid; m_pay = n_pay; m_stall = n_stall; m_flush = n_flush;
        checks++;
        if (ex_valid_o !== m_valid) begin
            errors++; $display("FAIL rand_ex_valid: got %b want %b", ex_valid_o, m_valid);
        end
        if (m_valid) begin
            checks++;
            if (act_pay !== m_pay) begin
                errors++; $display("FAIL rand_payload: got %h want %h", act_pay, m_pay);
            end
        end
        checks++;
        if ({stall_cnt_o, flush_cnt_o} !== {16'(m_stall), 16'(m_flush)}) begin
            errors++; $display("FAIL rand_counters: got %0d/%0d want %0d/%0d", stall_cnt_o, flush_cnt_o, m_stall, m_flush);
        end
        checks++;
        if ({s_stall_cnt, s_flush_cnt} !== {2'((m_stall > 3) ? 3 : m_stall), 2'((m_flush > 3) ? 3 : m_flush)}) begin
            errors++; $display("FAIL rand_sat_counters: got %0d/%0d want min(%0d,3)/min(%0d,3)",
                               s_stall_cnt, s_flush_cnt, m_stall, m_flush);
        end
        if (!init_mode && $urandom_range(0, 149) == 0) begin
            reset = 1'b1;
            #1;
            checks++;
            if (all_regs !== '0) begin
                errors++; $display("FAIL rand_reset: got %h want 0", all_regs);
            end
            reset = 1'b0;
            model_reset();
        end
    endtask

    task automatic test_random();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 'x;
        for (int i = 1; i < 32; i++) rand_cycle(1'b1, i);
        for (int i = 0; i < 3000; i++) rand_cycle(1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_decode();
        test_bypass();
        test_load_use();
        test_hold_flush();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
